// File: rtl/in_wrapper_top.sv
// Input-side wrapper for the FP32 multiplier: collects an A/B operand pair over a
// four-phase request/acknowledge handshake, launches the multiplier, waits for completion.
module in_wrapper_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        doneFP,
  input  logic        inReady,
  input  logic [31:0] inBus,
  output logic [31:0] ABus,
  output logic [31:0] BBus,
  output logic        inAccept,
  output logic        startFP
);

  localparam int unsigned W = 32;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    ACK_A  = 3'd1,
    WAIT_B = 3'd2,
    ACK_B  = 3'd3,
    START  = 3'd4,
    BUSY   = 3'd5
  } state_t;

  state_t state;

  // Outputs are registered alongside the state so each one equals its state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_A;
      ABus     <= W'(0);
      BBus     <= W'(0);
      inAccept <= 1'b0;
      startFP  <= 1'b0;
    end else begin
      startFP <= 1'b0;
      case (state)
        WAIT_A: begin
          if (inReady) begin
            ABus     <= inBus;
            inAccept <= 1'b1;
            state    <= ACK_A;
          end
        end
        ACK_A: begin
          // Requester must drop inReady before B is taken, so one request loads one word.
          if (!inReady) begin
            inAccept <= 1'b0;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (inReady) begin
            BBus     <= inBus;
            inAccept <= 1'b1;
            state    <= ACK_B;
          end
        end
        ACK_B: begin
          if (!inReady) begin
            inAccept <= 1'b0;
            startFP  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          state <= BUSY;
        end
        BUSY: begin
          if (doneFP) begin
            state <= WAIT_A;
          end
        end
        default: begin
          inAccept <= 1'b0;
          state    <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_wrapper_top.sv
// Scoreboard bench for in_wrapper_top: producer-side driver pushes expected operand pairs,
// an independent monitor pops and checks them on every startFP pulse.
module tb_in_wrapper_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        doneFP;
  logic        inReady;
  logic [31:0] inBus;
  logic [31:0] ABus;
  logic [31:0] BBus;
  logic        inAccept;
  logic        startFP;

  always #5 clk = ~clk;

  in_wrapper_top dut (
    .clk      (clk),
    .rst      (rst),
    .doneFP   (doneFP),
    .inReady  (inReady),
    .inBus    (inBus),
    .ABus     (ABus),
    .BBus     (BBus),
    .inAccept (inAccept),
    .startFP  (startFP)
  );

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_start = 0;
  int          n_pairs = 0;
  logic [31:0] mA = 32'h0;
  logic [31:0] mB = 32'h0;
  logic [63:0] exp_q[$];
  logic        prev_start = 1'b0;
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must launch the oldest issued pair and last one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_start <= 1'b0;
    end else begin
      if (startFP) begin
        check("start_width", 32'(prev_start), 32'h0);
        n_start++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL start_unexpected: got startFP=1 expected no pending pair at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pair_A", ABus, mon_e[63:32]);
          check("pair_B", BBus, mon_e[31:0]);
        end
      end
      prev_start <= startFP;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  // One request/acknowledge transfer; called just after a negedge with the DUT waiting.
  task automatic hs(input logic [31:0] w, input int hold, input bit isb);
    inReady = 1'b1;
    inBus   = w;
    doneFP  = 1'($urandom);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (isb) mB = w;
        else     mA = w;
      end
      check(isb ? "ack_B" : "ack_A", 32'(inAccept), 32'h1);
      check("reg_A", ABus, mA);
      check("reg_B", BBus, mB);
      inBus  = $urandom;
      doneFP = 1'($urandom);
    end
    inReady = 1'b0;
    inBus   = $urandom;
  endtask

  // Asynchronous reset asserted mid-cycle, away from any clock edge.
  task automatic rst_mid();
    #2 rst = 1'b1;
    #1;
    check("rst_A", ABus, 32'h0);
    check("rst_B", BBus, 32'h0);
    check("rst_accept", 32'(inAccept), 32'h0);
    check("rst_start", 32'(startFP), 32'h0);
    inReady = 1'b0;
    doneFP  = 1'b0;
    mA = 32'h0;
    mB = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full pair: A transfer, gap, B transfer, then the multiplier busy window of d cycles.
  task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int hold_a,
                         input int hold_b, input int gap, input int d, input bit early,
                         input bit rst_busy);
    int ret;
    hs(a, hold_a, 1'b0);
    @(negedge clk);
    check("rel_A", 32'(inAccept), 32'h0);
    for (int g = 0; g < gap; g++) begin
      doneFP = 1'($urandom);
      inBus  = $urandom;
      @(negedge clk);
      check("gap_accept", 32'(inAccept), 32'h0);
    end
    hs(b, hold_b, 1'b1);
    exp_q.push_back({a, b});
    n_pairs++;
    // WAIT_A becomes visible one cycle after doneFP is seen in BUSY (BUSY is entered at c=2).
    ret = (d == 0) ? 3 : d + 2;
    for (int c = 1; c <= ret; c++) begin
      @(negedge clk);
      check("busy_accept", 32'(inAccept), 32'h0);
      check("busy_A", ABus, a);
      check("busy_B", BBus, b);
      if (rst_busy && c == 2) begin
        rst_mid();
        return;
      end
      doneFP = (c >= 1 + d && c < ret) ? 1'b1 : 1'b0;
      inBus  = $urandom;
      if (early && c == ret - 1) inReady = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst     = 1'b1;
    doneFP  = 1'b0;
    inReady = 1'b0;
    inBus   = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("init_A", ABus, 32'h0);
    check("init_B", BBus, 32'h0);
    check("init_accept", 32'(inAccept), 32'h0);
    check("init_start", 32'(startFP), 32'h0);
    rst = 1'b0;

    // Basic pair with long held requests and stray doneFP before START.
    do_pair(32'h42FA4000, 32'h41410000, 9, 29, 0, 0, 1'b0, 1'b0);
    // Completion held off for 5 busy cycles, then a new A of 1.0.
    do_pair(32'h40490FDB, 32'hC0000000, 0, 0, 1, 5, 1'b1, 1'b0);
    do_pair(32'h3F800000, 32'h3F000000, 2, 1, 0, 1, 1'b0, 1'b0);

    // Reset during ACK_B: no start pulse, next handshake loads A.
    hs(32'h12345678, 1, 1'b0);
    @(negedge clk);
    check("rel_A", 32'(inAccept), 32'h0);
    inReady = 1'b1;
    inBus   = 32'h9ABCDEF0;
    @(negedge clk);
    mB = 32'h9ABCDEF0;
    check("ackB_pre_rst", 32'(inAccept), 32'h1);
    check("reg_B_pre_rst", BBus, mB);
    rst_mid();
    do_pair(32'hBF800000, 32'h7F7FFFFF, 1, 0, 0, 2, 1'b0, 1'b0);

    // Reset during BUSY.
    do_pair(32'h00000001, 32'h80000000, 0, 2, 2, 4, 1'b0, 1'b1);
    do_pair(32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      do_pair(ra, rb, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              (n != 29) ? 1'($urandom) : 1'b0, 1'b0);
    end

    inReady = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("start_count", 32'(n_start), 32'(n_pairs));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
